// File: rtl/const_narrow_if.sv
// Handshake bundle for const_narrow: command input stream and narrowed-result output stream.
interface const_narrow_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] palavraEntrada;
  logic [1:0]  controle;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] palavraSaida;
  logic        out_last;
  logic        overflow;
  logic        erro;

  modport master (
    output in_valid, palavraEntrada, controle, out_ready,
    input  in_ready, out_valid, palavraSaida, out_last, overflow, erro
  );

  modport slave (
    input  in_valid, palavraEntrada, controle, out_ready,
    output in_ready, out_valid, palavraSaida, out_last, overflow, erro
  );
endinterface

// File: rtl/const_narrow.sv
// Narrows a 16-bit signed word to an 11-bit field: signed narrow, hi/lo split,
// or high byte, emitting one or two output beats per accepted command.
module const_narrow (
  input  logic           clock,
  input  logic           reset_n,
  const_narrow_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ONE, HI, LO} state_t;

  state_t      state, state_next;
  logic [15:0] word_q;
  logic [1:0]  mode_q;
  logic        accept;
  logic        ovf_signed;

  // Beats are decoded from the captured word, so they stay stable while stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      word_q <= '0;
      mode_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_q <= bus.palavraEntrada;
        mode_q <= bus.controle;
      end
    end
  end

  always_comb begin
    bus.in_ready = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE:    bus.in_ready = 1'b1;
        ONE, LO: bus.in_ready = bus.out_ready;
        default: bus.in_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = (bus.controle == 2'b01) ? HI : ONE;
      end
      HI: begin
        if (bus.out_ready) state_next = LO;
      end
      ONE, LO: begin
        if (bus.out_ready) begin
          if (accept) state_next = (bus.controle == 2'b01) ? HI : ONE;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Value fits in 11 signed bits only when bits [15:10] are all equal.
  assign ovf_signed = ~((&word_q[15:10]) | ~(|word_q[15:10]));

  always_comb begin
    bus.out_valid    = 1'b0;
    bus.palavraSaida = '0;
    bus.out_last     = 1'b0;
    bus.overflow     = 1'b0;
    bus.erro         = 1'b0;
    unique case (state)
      ONE: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        unique case (mode_q)
          2'b00: begin
            bus.palavraSaida = word_q[10:0];
            bus.overflow     = ovf_signed;
          end
          2'b10: begin
            bus.palavraSaida = {3'b000, word_q[15:8]};
            bus.overflow     = |word_q[7:0];
          end
          2'b11: bus.erro = 1'b1;
          default: bus.palavraSaida = '0;
        endcase
      end
      HI: begin
        bus.out_valid    = 1'b1;
        bus.palavraSaida = {3'b000, word_q[15:8]};
      end
      LO: begin
        bus.out_valid    = 1'b1;
        bus.out_last     = 1'b1;
        bus.palavraSaida = {3'b000, word_q[7:0]};
      end
      default: bus.out_valid = 1'b0;
    endcase
  end

endmodule

// File: doc/const_narrow.md
CONST_NARROW -- requirements
Module: const_narrow

Interface
REQ-001 SHALL have port: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  in  1  one clock; reset is synchronous and active-low.
REQ-003 SHALL have port: in_valid  in  1  input word/command present.
REQ-004 SHALL have port: in_ready  out  1  block accepts input this cycle.
REQ-005 SHALL have port: palavraEntrada  in  16  signed ALU-width word to narrow.
REQ-006 SHALL have port: controle  in  2  mode: 00 narrow-signed, 01 split hi/lo, 10 high-byte, 11 reserved.
REQ-007 SHALL have port: out_valid  out  1  output beat present.
REQ-008 SHALL have port: out_ready  in  1  consumer takes beat this cycle.
REQ-009 SHALL have port: palavraSaida  out  11  constant-field-width result.
REQ-010 SHALL have port: out_last  out  1  final beat of the current command.
REQ-011 SHALL have port: overflow  out  1  significant bits lost in narrowing.
REQ-012 SHALL have port: erro  out  1  reserved controle value received.

Function
REQ-013 SHALL transfer input when in_valid && in_ready, and output beat when out_valid && out_ready.
REQ-014 SHALL capture palavraEntrada and controle in registers on accept; result beat appears with out_valid=1 the next cycle (latency 1).
REQ-015 SHALL implement FSM states IDLE, ONE (single beat pending), HI (split high beat pending), LO (split low beat pending).
REQ-016 Transitions: IDLE + accept mode 00/10/11 -> ONE; IDLE + accept mode 01 -> HI; HI + out_ready -> LO; ONE/LO + out_ready + accept -> ONE or HI per new mode; ONE/LO + out_ready, no accept -> IDLE; any state without out_ready -> hold.
REQ-017 in_ready SHALL be 1 in IDLE, (out_ready) in ONE and LO, 0 in HI; sustained throughput 1 command/cycle for single-beat modes.
REQ-018 Mode 00: palavraSaida = palavraEntrada[10:0]; overflow = 1 iff bits [15:10] not all equal (value outside -1024..1023); out_last = 1.
REQ-019 Mode 01: HI beat palavraSaida = {3'b000, word[15:8]}, out_last 0; LO beat palavraSaida = {3'b000, word[7:0]}, out_last 1; overflow 0 on both.
REQ-020 Mode 10: palavraSaida = {3'b000, word[15:8]}; overflow = 1 iff word[7:0] != 0; out_last 1.
REQ-021 Mode 11: single beat, palavraSaida = 0, erro = 1, overflow 0, out_last 1; erro = 0 on all other beats.
REQ-022 While out_valid && !out_ready, palavraSaida, out_last, overflow, erro SHALL hold stable; no input accepted in HI; the captured word is not overwritten.
REQ-023 in_valid deasserted or palavraEntrada/controle changing while in_ready=0 SHALL have no effect.

Reset
REQ-024 When reset_n = 0 at a rising edge: state -> IDLE, out_valid, out_last, overflow, erro, palavraSaida -> 0, captured registers -> 0.
REQ-025 in_ready SHALL read 0 in any cycle where reset_n = 0.
REQ-026 Reset in HI or LO SHALL discard the pending beat(s); no LO beat is emitted after reset release.
REQ-027 Reset priority SHALL exceed simultaneous accept or output handshake in the same cycle.

Verification
REQ-028 Mode 00, out_ready=1: 16'h03FF -> 11'h3FF ovf 0; 16'hFC00 -> 11'h400 ovf 0; 16'h0400 -> 11'h400 ovf 1; back-to-back, one beat per cycle.
REQ-029 Mode 01, 16'hA55A, out_ready=1 -> beat1 11'h0A5 last 0, beat2 11'h05A last 1; in_ready 0 during beat1.
REQ-030 Mode 01 with out_ready low 3 cycles during HI -> palavraSaida holds 11'h0A5, in_ready 0, then LO beat follows release.
REQ-031 Mode 10: 16'h1200 -> 11'h012 ovf 0; 16'h1201 -> 11'h012 ovf 1.
REQ-032 Mode 11 any word -> one beat 11'h000, erro 1, last 1; next mode 00 beat has erro 0.
REQ-033 reset_n low one cycle while in LO -> next cycle out_valid 0, state IDLE, in_ready 1 after release, no LO beat observed.
